// File: rtl/dbf_ch_interp.sv
// DBF receive channel: coarse delay ring buffer, linear fractional interpolation,
// apodisation weight, then round-half-up and saturate to the summing-tree width.
module dbf_ch_interp #(
    parameter int unsigned INPUT_WD = 14,
    parameter int unsigned APO_WD   = 16,
    parameter int unsigned FRAC_WD  = 4,
    parameter int unsigned CD_WD    = 10,
    parameter int unsigned LUT_AW   = 10,
    parameter int unsigned OUT_WD   = 32,
    parameter int unsigned SHIFT    = 19
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic        [LUT_AW-1:0]        nsamp,
    input  logic signed [INPUT_WD-1:0]      ch_in,
    input  logic                            ch_in_valid,
    input  logic signed [APO_WD-1:0]        apo_din,
    input  logic        [LUT_AW-1:0]        lut_addr,
    input  logic        [CD_WD+FRAC_WD-1:0] lut_din,
    input  logic                            lut_we,
    output logic signed [OUT_WD-1:0]        dout,
    output logic                            dout_valid,
    output logic                            busy,
    output logic                            done,
    output logic                            dly_err
);

    localparam int unsigned DEPTH     = 2 ** CD_WD;
    localparam int unsigned LUT_DEPTH = 2 ** LUT_AW;
    localparam int unsigned LUT_DW    = CD_WD + FRAC_WD;
    localparam int unsigned IW        = INPUT_WD + FRAC_WD + 2;
    localparam int unsigned PW        = IW + APO_WD;
    localparam int unsigned SW        = (PW + 1 > OUT_WD) ? PW + 2 : OUT_WD + 1;
    localparam int unsigned RND_POS   = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [CD_WD-1:0]      C_MAX = CD_WD'(DEPTH - 2);
    localparam logic [CD_WD:0]        W_SAT = (CD_WD + 1)'(DEPTH);
    localparam logic signed [SW-1:0]  RND   = (SHIFT > 0) ? (SW'(1) << RND_POS) : '0;
    localparam logic signed [SW-1:0]  OMAX  = {{(SW - OUT_WD + 1){1'b0}}, {(OUT_WD - 1){1'b1}}};
    localparam logic signed [SW-1:0]  OMIN  = {{(SW - OUT_WD + 1){1'b1}}, {(OUT_WD - 1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state, state_n;

    logic signed [INPUT_WD-1:0] buf_mem [DEPTH];
    logic        [LUT_DW-1:0]   lut_mem [LUT_DEPTH];

    logic [CD_WD-1:0]  wr_ptr;
    logic [CD_WD:0]    wcnt, wcnt_inc;
    logic [LUT_AW-1:0] k, nsamp_q;
    logic              all_in;

    logic               accept, clamp, z0, z1;
    logic [LUT_DW-1:0]  lut_word;
    logic [CD_WD-1:0]   c_raw, c_eff, rd0, rd1;
    logic [FRAC_WD-1:0] f_raw, f1_q;

    logic                       v1, v2, v3, last1, last2, last3, dout_last;
    logic signed [INPUT_WD-1:0] s0_q, s1_q;
    logic signed [APO_WD-1:0]   apo1_q, apo2_q;
    logic signed [IW-1:0]       s0_x, s1_x, f_x, interp_c, interp_q;
    logic signed [PW-1:0]       prod_q;
    logic signed [SW-1:0]       shr_c;
    logic signed [OUT_WD-1:0]   sat_c;

    // Accept-cycle address generation; slot c+1 back may equal the next write slot, read before write.
    always_comb begin
        accept   = (state == S_RUN) && ch_in_valid && !start && !all_in;
        lut_word = lut_mem[k];
        c_raw    = lut_word[LUT_DW-1:FRAC_WD];
        f_raw    = lut_word[FRAC_WD-1:0];
        clamp    = c_raw > C_MAX;
        c_eff    = clamp ? C_MAX : c_raw;
        wcnt_inc = (wcnt == W_SAT) ? wcnt : wcnt + (CD_WD + 1)'(1);
        rd0      = wr_ptr - c_eff;
        rd1      = rd0 - CD_WD'(1);
        z0       = {1'b0, c_eff} >= wcnt_inc;
        z1       = ({1'b0, c_eff} + (CD_WD + 1)'(1)) >= wcnt_inc;
    end

    always_comb begin
        s0_x     = IW'(s0_q);
        s1_x     = IW'(s1_q);
        f_x      = IW'({1'b0, f1_q});
        interp_c = (s0_x <<< FRAC_WD) + f_x * (s1_x - s0_x);
    end

    always_comb begin
        shr_c = (SW'(prod_q) + RND) >>> SHIFT;
        sat_c = OUT_WD'(shr_c);
        if (shr_c > OMAX) begin
            sat_c = OUT_WD'(OMAX);
        end else if (shr_c < OMIN) begin
            sat_c = OUT_WD'(OMIN);
        end
    end

    // Storage and datapath stages; validity is tracked in the control block.
    always_ff @(posedge clk) begin
        if (lut_we && state != S_RUN) begin
            lut_mem[lut_addr] <= lut_din;
        end
        if (accept) begin
            buf_mem[wr_ptr] <= ch_in;
            s0_q   <= z0 ? '0 : ((c_eff == '0) ? ch_in : buf_mem[rd0]);
            s1_q   <= z1 ? '0 : buf_mem[rd1];
            f1_q   <= f_raw;
            apo1_q <= apo_din;
            last1  <= (k == nsamp_q);
        end
        interp_q <= interp_c;
        apo2_q   <= apo1_q;
        last2    <= last1;
        prod_q   <= PW'(interp_q) * PW'(apo2_q);
        last3    <= last2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            dly_err    <= 1'b0;
            wr_ptr     <= '0;
            wcnt       <= '0;
            k          <= '0;
            nsamp_q    <= '0;
            all_in     <= 1'b0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            dout       <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n == S_RUN);
            done  <= (state_n == S_DONE);
            if (start) begin
                wr_ptr     <= '0;
                wcnt       <= '0;
                k          <= '0;
                nsamp_q    <= nsamp;
                all_in     <= 1'b0;
                v1         <= 1'b0;
                v2         <= 1'b0;
                v3         <= 1'b0;
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end else begin
                v1         <= accept;
                v2         <= v1;
                v3         <= v2;
                dout_valid <= v3;
                dout_last  <= v3 && last3;
                if (v3) begin
                    dout <= sat_c;
                end
                if (accept) begin
                    wr_ptr <= wr_ptr + CD_WD'(1);
                    wcnt   <= wcnt_inc;
                    if (k == nsamp_q) begin
                        all_in <= 1'b1;
                    end else begin
                        k <= k + LUT_AW'(1);
                    end
                    if (clamp) begin
                        dly_err <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_RUN;
            S_RUN:   if (!start && dout_valid && dout_last) state_n = S_DONE;
            S_DONE:  state_n = start ? S_RUN : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dbf_ch_interp.sv
// Directed bench for dbf_ch_interp: default instance plus a 16-bit, SHIFT=0 instance for saturation.
module tb_dbf_ch_interp;

    localparam int unsigned INPUT_WD = 14;
    localparam int unsigned APO_WD   = 16;
    localparam int unsigned FRAC_WD  = 4;
    localparam int unsigned CD_WD    = 10;
    localparam int unsigned LUT_AW   = 10;
    localparam int unsigned OUT_WD   = 32;
    localparam int unsigned OUT2_WD  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic                        start = 1'b0, ch_in_valid = 1'b0, lut_we = 1'b0;
    logic        [LUT_AW-1:0]    nsamp = '0, lut_addr = '0;
    logic signed [INPUT_WD-1:0]  ch_in = '0;
    logic signed [APO_WD-1:0]    apo_din = '0;
    logic [CD_WD+FRAC_WD-1:0]    lut_din = '0;
    logic signed [OUT_WD-1:0]    dout;
    logic                        dout_valid, busy, done, dly_err;

    logic                        start2 = 1'b0, ch_in_valid2 = 1'b0, lut_we2 = 1'b0;
    logic        [LUT_AW-1:0]    nsamp2 = '0, lut_addr2 = '0;
    logic signed [INPUT_WD-1:0]  ch_in2 = '0;
    logic signed [APO_WD-1:0]    apo2 = '0;
    logic [CD_WD+FRAC_WD-1:0]    lut_din2 = '0;
    logic signed [OUT2_WD-1:0]   dout2;
    logic                        dout_valid2, busy2, done2, dly_err2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic signed [OUT_WD-1:0]  out_q[$];
    logic signed [OUT2_WD-1:0] out2_q[$];
    int out_cyc[$];
    int in_cyc[$];

    dbf_ch_interp dut (
        .clk(clk), .rst_n(rst_n), .start(start), .nsamp(nsamp),
        .ch_in(ch_in), .ch_in_valid(ch_in_valid), .apo_din(apo_din),
        .lut_addr(lut_addr), .lut_din(lut_din), .lut_we(lut_we),
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done), .dly_err(dly_err)
    );

    dbf_ch_interp #(.OUT_WD(OUT2_WD), .SHIFT(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .nsamp(nsamp2),
        .ch_in(ch_in2), .ch_in_valid(ch_in_valid2), .apo_din(apo2),
        .lut_addr(lut_addr2), .lut_din(lut_din2), .lut_we(lut_we2),
        .dout(dout2), .dout_valid(dout_valid2), .busy(busy2), .done(done2), .dly_err(dly_err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output capture on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (dout_valid) begin
            out_q.push_back(dout);
            out_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (dout_valid2) out2_q.push_back(dout2);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic lut_fill(input int c, input int f);
        for (int i = 0; i < 2 ** LUT_AW; i++) begin
            tick();
            lut_we   = 1'b1;
            lut_addr = LUT_AW'(i);
            lut_din  = {CD_WD'(c), FRAC_WD'(f)};
        end
        tick();
        lut_we = 1'b0;
    endtask

    task automatic begin_line(input int n);
        tick();
        start = 1'b1;
        nsamp = LUT_AW'(n);
        tick();
        start = 1'b0;
        out_q.delete();
        out_cyc.delete();
        in_cyc.delete();
    endtask

    task automatic feed(input int v);
        ch_in       = INPUT_WD'(v);
        ch_in_valid = 1'b1;
        in_cyc.push_back(cyc);
        tick();
        ch_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            #1;
            n++;
        end
        chk(tag, done_cnt, target);
    endtask

    initial begin
        int d0;
        int sz;

        // Reset state, then input strobes while idle must produce nothing.
        repeat (3) tick();
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dly_err", dly_err, 0);
        rst_n = 1'b1;
        apo_din = 16'sh7FFF;
        for (int i = 0; i < 10; i++) feed(123);
        repeat (6) tick();
        #1;
        chk("idle_no_valid", out_q.size(), 0);
        chk("idle_no_done", done_cnt, 0);
        chk("idle_busy", busy, 0);

        // Unit passthrough with a ramp.
        lut_fill(0, 0);
        d0 = done_cnt;
        begin_line(99);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) chk("pass_busy", busy, 1);
            feed(i);
        end
        wait_done(d0 + 1, 40, "pass_done_seen");
        chk("pass_count", out_q.size(), 100);
        for (int i = 0; i < out_q.size() && i < 100; i++)
            chk($sformatf("pass_dout[%0d]", i), out_q[i], i);
        if (out_q.size() == 100) begin
            chk("pass_lat_first", out_cyc[0] - in_cyc[0], 4);
            chk("pass_lat_last", out_cyc[99] - in_cyc[99], 4);
            chk("pass_done_gap", done_cyc - out_cyc[99], 1);
        end
        tick();
        #1;
        chk("pass_done_pulse", done, 0);
        chk("pass_busy_after", busy, 0);

        // Coarse delay of 5 with empty history reading as zero.
        lut_fill(5, 0);
        apo_din = 16'sh4000;
        d0 = done_cnt;
        begin_line(9);
        for (int i = 0; i < 10; i++) feed(1000);
        wait_done(d0 + 1, 40, "coarse_done_seen");
        chk("coarse_count", out_q.size(), 10);
        for (int i = 0; i < out_q.size() && i < 10; i++)
            chk($sformatf("coarse_dout[%0d]", i), out_q[i], (i < 5) ? 0 : 500);
        chk("coarse_dly_err", dly_err, 0);

        // Half-sample interpolation between s[n-2] and s[n-3].
        lut_fill(2, 8);
        apo_din = 16'sh7FFF;
        d0 = done_cnt;
        begin_line(19);
        for (int i = 0; i < 20; i++) feed(16 * i);
        wait_done(d0 + 1, 40, "frac_done_seen");
        chk("frac_count", out_q.size(), 20);
        for (int i = 0; i < out_q.size() && i < 20; i++)
            chk($sformatf("frac_dout[%0d]", i), out_q[i], (i < 3) ? 0 : 16 * i - 40);

        // Coarse value 1023 clamps to 1022.
        lut_fill(1023, 0);
        d0 = done_cnt;
        begin_line(1023);
        for (int i = 0; i < 1024; i++) feed(i);
        wait_done(d0 + 1, 40, "clamp_done_seen");
        chk("clamp_count", out_q.size(), 1024);
        if (out_q.size() == 1024) begin
            chk("clamp_dout_1021", out_q[1021], 0);
            chk("clamp_dout_1022", out_q[1022], 0);
            chk("clamp_dout_1023", out_q[1023], 1);
        end
        chk("clamp_dly_err", dly_err, 1);

        // Restart mid-line, with a LUT write attempted while running.
        lut_fill(0, 0);
        d0 = done_cnt;
        begin_line(99);
        for (int i = 0; i < 41; i++) feed(i);
        start = 1'b1;
        nsamp = LUT_AW'(9);
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                lut_we   = 1'b1;
                lut_addr = LUT_AW'(5);
                lut_din  = {CD_WD'(3), FRAC_WD'(0)};
            end else begin
                lut_we = 1'b0;
            end
            feed(100 + i);
        end
        lut_we = 1'b0;
        wait_done(d0 + 1, 40, "restart_done_seen");
        repeat (3) tick();
        #1;
        chk("restart_one_done", done_cnt, d0 + 1);
        chk("restart_count", out_q.size(), 48);
        if (out_q.size() == 48) begin
            chk("restart_last_old", out_q[37], 37);
            chk("restart_first_new", out_q[38], 100);
            chk("restart_lut_kept", out_q[43], 105);
            chk("restart_last_new", out_q[47], 109);
        end
        chk("restart_dly_err_kept", dly_err, 1);

        // Reset in the middle of a line.
        d0 = done_cnt;
        begin_line(99);
        for (int i = 0; i < 20; i++) feed(i + 1);
        rst_n = 1'b0;
        tick();
        #1;
        sz = out_q.size();
        chk("mrst_dout", dout, 0);
        chk("mrst_valid", dout_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_dly_err", dly_err, 0);
        rst_n = 1'b1;
        repeat (10) tick();
        #1;
        chk("mrst_no_more_valid", out_q.size(), sz);
        chk("mrst_no_done", done_cnt, d0);

        // Saturating instance: OUT_WD=16, SHIFT=0.
        tick();
        lut_we2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lut_addr2 = LUT_AW'(i);
            lut_din2  = '0;
            tick();
        end
        lut_we2 = 1'b0;
        start2  = 1'b1;
        nsamp2  = LUT_AW'(2);
        tick();
        start2       = 1'b0;
        ch_in_valid2 = 1'b1;
        apo2         = 16'sh7FFF;
        ch_in2       = INPUT_WD'(8191);
        tick();
        ch_in2 = INPUT_WD'(-8192);
        tick();
        ch_in2 = INPUT_WD'(1);
        apo2   = 16'sh0001;
        tick();
        ch_in_valid2 = 1'b0;
        repeat (8) tick();
        #1;
        chk("sat_count", out2_q.size(), 3);
        if (out2_q.size() == 3) begin
            chk("sat_pos", out2_q[0], 32767);
            chk("sat_neg", out2_q[1], -32768);
            chk("sat_noround", out2_q[2], 16);
        end
        chk("sat_dly_err", dly_err2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbf_ch_interp.md
Name: dbf_ch_interp

Overview:
- Parametrised next-generation DBF receive channel: coarse delay (circular sample buffer), fractional fine delay by linear interpolation, apodisation multiply, then round and saturate to the summing-tree width.
- Delay profile comes from a per-output-sample LUT, so dynamic receive focusing is per sample, not per zone.
- One instance per element; outputs feed the channel summation tree.

Parameters:
- INPUT_WD, 14, ADC sample width, signed.
- APO_WD, 16, apodisation weight width, signed Q1.(APO_WD-1).
- FRAC_WD, 4, fine-delay fraction bits (1/2^FRAC_WD sample resolution).
- CD_WD, 10, coarse-delay width; buffer depth is 2^CD_WD.
- LUT_AW, 10, delay-LUT address width; also sets max output samples per line (2^LUT_AW).
- OUT_WD, 32, output width, signed.
- SHIFT, 19, right shift applied to the product before output (default FRAC_WD+APO_WD-1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a receive line.
- nsamp  in  LUT_AW  output samples per line minus 1; latched on start.
- ch_in  in  INPUT_WD  signed input sample.
- ch_in_valid  in  1  sample strobe.
- apo_din  in  APO_WD  signed apodisation weight; sampled with ch_in_valid.
- lut_addr  in  LUT_AW  delay-LUT write address.
- lut_din  in  CD_WD+FRAC_WD  LUT entry: {coarse, frac}.
- lut_we  in  1  LUT write enable.
- dout  out  OUT_WD  signed delayed, interpolated, apodised sample.
- dout_valid  out  1  dout strobe.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the last output is produced.
- dly_err  out  1  sticky; set when a LUT coarse value was clamped.

Behaviour:
- Reset (rst_n low at a clk edge): dout=0, dout_valid=0, busy=0, done=0, dly_err=0, state=IDLE, all pointers and counters 0. Buffer and LUT contents are not cleared. Reset mid-line aborts the line immediately; no further dout_valid.
- States:
  - IDLE: busy=0. start goes to RUN.
  - RUN: busy=1. Goes to DONE when the output counter's last sample leaves the pipeline.
  - DONE: busy=0, done=1 for exactly one cycle, then IDLE.
- start in RUN restarts the line: pipeline is flushed (no dout_valid for in-flight samples), counters are cleared, dly_err is kept.
- LUT writes are honoured only in IDLE and DONE; lut_we in RUN is ignored.
- Per accepted sample in RUN (ch_in_valid=1), with k = output index and {c,f} = LUT[k]:
  - ch_in is written at wr_ptr; wr_ptr increments modulo 2^CD_WD; wcnt saturates at 2^CD_WD.
  - If c > 2^CD_WD-2, c is clamped to 2^CD_WD-2 and dly_err is set.
  - s0 = sample c back, s1 = sample c+1 back. When c=0, s0 is ch_in (bypass).
  - A sample not yet written this line (index back >= wcnt) reads as 0.
  - Interpolation: interp = (s0<<FRAC_WD) + f*(s1-s0), computed at full width INPUT_WD+FRAC_WD+2, signed.
  - prod = interp*apo_din at full width.
  - dout = saturate_OUT_WD((prod + 2^(SHIFT-1)) >>> SHIFT), i.e. round half up, then clip to [-2^(OUT_WD-1), 2^(OUT_WD-1)-1].
- Latency: dout_valid asserts exactly 4 clk cycles after the accepted ch_in_valid cycle. Pipeline stages: addr/write, buffer read, interpolate, multiply, round/sat.
- Outputs are produced one per accepted input. k increments per accepted input; after nsamp+1 accepted inputs, further inputs are ignored until the next start. The last output's dout_valid is followed one cycle later by done.
- Buffer wrap: pointer arithmetic is modulo 2^CD_WD. A delay never addresses the slot currently being written, which the clamp guarantees.
- ch_in_valid gaps stall nothing; in-flight stages advance every clk. dout_valid=0 means dout holds its last value.

Test Plan:
- Reset check: reset pulse, then ch_in_valid bursts in IDLE -> dout=0, dout_valid=0, busy=0, no done.
- Unit passthrough: LUT all {0,0}, apo=0x7FFF (≈1.0), SHIFT=19, ramp 0..99, nsamp=99 -> dout[k]=k*0x7FFF>>15 rounded, i.e. k for k<2^14. Valid 4 cycles after each input; done one cycle after output 99.
- Coarse delay plus history zero: LUT {5,0}, apo=0x4000, input constant 1000 -> first 5 outputs 0, then 500 each; dly_err=0.
- Fractional interpolation: LUT {2,8} (0.5 sample), apo=0x7FFF, input s[n]=16n -> dout = 16n-40 once history is valid (mean of s[n-2] and s[n-3]).
- Clamp and saturate: LUT {1023,0} with CD_WD=10 -> dly_err=1, effective delay 1022. Separately, OUT_WD=16, input 8191, apo=0x7FFF, SHIFT=0 -> dout=32767.
- Restart, mid-line LUT write and mid-line reset: start at output 40 -> no valid for in-flight samples, k restarts at 0. lut_we during RUN -> LUT unchanged. rst_n low at output 20 -> all outputs 0 next cycle, busy=0, no done.
